// File: rtl/dti_rsp_tbu_arb_if.sv
// Response-side bundle of the TBU arbiter: NUM_SRC input streams merged onto one output stream.
// The slave modport is the arbiter's view; master is the view of the surrounding fabric.
interface dti_rsp_tbu_arb_if #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 80,
   parameter int unsigned KEEP_WIDTH = 10,
   parameter int unsigned TID_WIDTH  = 6
);
   logic [NUM_SRC-1:0]            s_tvalid;
   logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
   logic [NUM_SRC*KEEP_WIDTH-1:0] s_tkeep;
   logic [NUM_SRC-1:0]            s_tlast;
   logic [NUM_SRC-1:0]            s_tready;

   logic                          m_tvalid;
   logic [DATA_WIDTH-1:0]         m_tdata;
   logic [KEEP_WIDTH-1:0]         m_tkeep;
   logic                          m_tlast;
   logic [TID_WIDTH-1:0]          m_ttid;
   logic                          m_tready;

   modport slave (
      input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
      output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_ttid
   );

   modport master (
      output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
      input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_ttid
   );
endinterface

// File: rtl/dti_rsp_tbu_arb.sv
// Packet-locked round-robin merge of TBU response streams into a 2-entry output skid buffer,
// with an over-length packet detector.
module dti_rsp_tbu_arb #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 80,
   parameter int unsigned KEEP_WIDTH = 10,
   parameter int unsigned TID_WIDTH  = 6,
   parameter int unsigned MAX_BEATS  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   dti_rsp_tbu_arb_if.slave        rsp_if,
   output logic                    busy,
   output logic                    err_overlen
);
   localparam int unsigned SRC_W = $clog2(NUM_SRC);
   localparam int unsigned CNT_W = $clog2(MAX_BEATS + 2);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e                r_state;
   logic [SRC_W-1:0]      r_grant;
   logic [SRC_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]      r_beat_cnt;
   logic                  r_err;

   logic [DATA_WIDTH-1:0] r_buf_data [2];
   logic [KEEP_WIDTH-1:0] r_buf_keep [2];
   logic                  r_buf_last [2];
   logic [SRC_W-1:0]      r_buf_src  [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;

   logic [SRC_W-1:0]      w_gnt_idx;
   logic                  w_gnt_vld;
   logic [SRC_W-1:0]      w_cand;
   logic [SRC_W-1:0]      w_next_ptr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [KEEP_WIDTH-1:0] w_keep;
   logic                  w_last;
   logic                  w_valid;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [SRC_W-1:0] f_wrap(input int unsigned v);
      return SRC_W'(v % NUM_SRC);
   endfunction

   // Locked: hold the owner even while it idles. Idle: first valid at or after rr_ptr.
   always_comb begin
      w_gnt_idx = r_grant;
      w_gnt_vld = 1'b0;
      w_cand    = '0;
      if (r_state == StLocked) begin
         w_gnt_vld = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_cand = f_wrap(32'(r_rr_ptr) + k);
            if (!w_gnt_vld && rsp_if.s_tvalid[w_cand]) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = w_cand;
            end
         end
      end
   end

   assign w_full = (r_count == 2'd2);

   always_comb begin
      w_data          = '0;
      w_keep          = '0;
      w_last          = 1'b0;
      w_valid         = 1'b0;
      rsp_if.s_tready = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (SRC_W'(i) == w_gnt_idx) begin
            w_data             = rsp_if.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_keep             = rsp_if.s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            w_last             = rsp_if.s_tlast[i];
            w_valid            = rsp_if.s_tvalid[i];
            rsp_if.s_tready[i] = w_gnt_vld && !w_full && !rst;
         end
      end
   end

   assign w_push     = w_gnt_vld && !w_full && !rst && w_valid;
   assign w_pop      = (r_count != 2'd0) && rsp_if.m_tready;
   assign w_next_ptr = (32'(w_gnt_idx) == NUM_SRC - 1) ? '0 : w_gnt_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else if (w_push) begin
         // Beat MAX_BEATS+1 of a packet is over-length whether or not it carries tlast.
         if (r_beat_cnt >= CNT_W'(MAX_BEATS)) begin
            r_err <= 1'b1;
         end
         if (w_last) begin
            r_state    <= StIdle;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
         end else begin
            r_state <= StLocked;
            r_grant <= w_gnt_idx;
            if (r_beat_cnt != CNT_W'(MAX_BEATS + 1)) begin
               r_beat_cnt <= r_beat_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_data[r_wr_ptr] <= w_data;
         r_buf_keep[r_wr_ptr] <= w_keep;
         r_buf_last[r_wr_ptr] <= w_last;
         r_buf_src[r_wr_ptr]  <= w_gnt_idx;
      end
   end

   assign rsp_if.m_tvalid = (r_count != 2'd0);
   assign rsp_if.m_tdata  = r_buf_data[r_rd_ptr];
   assign rsp_if.m_tkeep  = r_buf_keep[r_rd_ptr];
   assign rsp_if.m_tlast  = r_buf_last[r_rd_ptr];
   assign rsp_if.m_ttid   = TID_WIDTH'(r_buf_src[r_rd_ptr]);
   assign busy            = (r_state == StLocked) || (r_count != 2'd0);
   assign err_overlen     = r_err;
endmodule

// File: tb/tb_dti_rsp_tbu_arb.sv
// Bench for dti_rsp_tbu_arb: queue-level reference model checked every cycle, plus directed
// scenarios with hand-computed order, latency and flag expectations.
module tb_dti_rsp_tbu_arb;
   localparam int NS = 4;
   localparam int DW = 80;
   localparam int KW = 10;
   localparam int TW = 6;
   localparam int MB = 16;

   typedef struct packed {
      logic          gap;
      logic          last;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } ibeat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [TW-1:0] tid;
   } obeat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic err_overlen;

   always #5 clk = ~clk;

   dti_rsp_tbu_arb_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TID_WIDTH(TW)) rsp_if ();

   dti_rsp_tbu_arb #(
      .NUM_SRC(NS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TID_WIDTH(TW), .MAX_BEATS(MB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rsp_if(rsp_if),
      .busy(busy),
      .err_overlen(err_overlen)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int pkt_id   = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Source drivers: one queue of beats per source, advanced on observed transfers.
   ibeat_t        src_q [NS][$];
   logic [NS-1:0] xfer      = '0;
   logic [NS-1:0] gap_shown = '0;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() > 0 && (xfer[i] || (src_q[i][0].gap && gap_shown[i])))
            void'(src_q[i].pop_front());
         gap_shown[i]       = 1'b0;
         rsp_if.s_tvalid[i] = 1'b0;
         if (src_q[i].size() > 0) begin
            if (src_q[i][0].gap) begin
               gap_shown[i] = 1'b1;
            end else begin
               rsp_if.s_tvalid[i]             = 1'b1;
               rsp_if.s_tdata[i*DW +: DW]     = src_q[i][0].data;
               rsp_if.s_tkeep[i*KW +: KW]     = src_q[i][0].keep;
               rsp_if.s_tlast[i]              = src_q[i][0].last;
            end
         end
      end
   end

   // Reference model: a FIFO of beats in flight, a lock owner and a round-robin pointer.
   obeat_t        mq[$];
   bit            mdl_locked = 0;
   int            mdl_owner  = 0;
   int            mdl_rr     = 0;
   int            mdl_cnt    = 0;
   bit            mdl_err    = 0;
   bit            prev_rst   = 0;

   int            out_tid[$];
   bit            out_last[$];
   logic [DW-1:0] out_data[$];
   int            out_cyc[$];
   int            in_cyc[$];

   always @(negedge clk) begin
      bit            found;
      int            g;
      logic [NS-1:0] exp_rdy;
      obeat_t        nb;
      cyc++;
      if (rst) begin
         if (prev_rst) begin
            check("rst_m_tvalid", 128'(rsp_if.m_tvalid), 128'(0));
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_err", 128'(err_overlen), 128'(0));
            check("rst_s_tready", 128'(rsp_if.s_tready), 128'(0));
         end
         mq.delete();
         mdl_locked = 0; mdl_owner = 0; mdl_rr = 0; mdl_cnt = 0; mdl_err = 0;
         xfer = '0;
      end else begin
         found = 0;
         g     = 0;
         if (mdl_locked) begin
            found = 1;
            g     = mdl_owner;
         end else begin
            for (int k = 0; k < NS; k++) begin
               if (!found && rsp_if.s_tvalid[(mdl_rr + k) % NS]) begin
                  found = 1;
                  g     = (mdl_rr + k) % NS;
               end
            end
         end
         exp_rdy = '0;
         if (found && mq.size() < 2) exp_rdy[g] = 1'b1;
         check("s_tready", 128'(rsp_if.s_tready), 128'(exp_rdy));
         check("m_tvalid", 128'(rsp_if.m_tvalid), 128'(mq.size() != 0));
         check("busy", 128'(busy), 128'(mdl_locked || mq.size() != 0));
         check("err_overlen", 128'(err_overlen), 128'(mdl_err));
         if (mq.size() != 0) begin
            check("m_tdata", 128'(rsp_if.m_tdata), 128'(mq[0].data));
            check("m_tkeep", 128'(rsp_if.m_tkeep), 128'(mq[0].keep));
            check("m_tlast", 128'(rsp_if.m_tlast), 128'(mq[0].last));
            check("m_ttid", 128'(rsp_if.m_ttid), 128'(mq[0].tid));
         end
         xfer = rsp_if.s_tvalid & rsp_if.s_tready;
         if (rsp_if.m_tvalid === 1'b1 && rsp_if.m_tready) begin
            out_tid.push_back(int'(rsp_if.m_ttid));
            out_last.push_back(rsp_if.m_tlast);
            out_data.push_back(rsp_if.m_tdata);
            out_cyc.push_back(cyc);
         end
         if (mq.size() != 0 && rsp_if.m_tready) void'(mq.pop_front());
         if (found && exp_rdy[g] && rsp_if.s_tvalid[g]) begin
            nb.data = rsp_if.s_tdata[g*DW +: DW];
            nb.keep = rsp_if.s_tkeep[g*KW +: KW];
            nb.last = rsp_if.s_tlast[g];
            nb.tid  = TW'(g);
            mq.push_back(nb);
            in_cyc.push_back(cyc);
            if (mdl_cnt >= MB) mdl_err = 1;
            if (nb.last) begin
               mdl_locked = 0;
               mdl_rr     = (g + 1) % NS;
               mdl_cnt    = 0;
            end else begin
               mdl_locked = 1;
               mdl_owner  = g;
               if (mdl_cnt < MB + 1) mdl_cnt++;
            end
         end
      end
      prev_rst = rst;
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic send_pkt(input int src, input int n, input int gap_before);
      ibeat_t b;
      pkt_id++;
      for (int j = 0; j < n; j++) begin
         if (j == gap_before) begin
            b     = '0;
            b.gap = 1'b1;
            src_q[src].push_back(b);
         end
         b             = '0;
         b.data[15:0]  = 16'(j);
         b.data[23:16] = 8'(src);
         b.data[39:24] = 16'(pkt_id);
         b.data[79:40] = 40'({$urandom(), $urandom()});
         b.keep        = KW'($urandom());
         b.last        = (j == n - 1);
         src_q[src].push_back(b);
      end
   endtask

   function automatic bit srcs_empty();
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 0;
      return 1;
   endfunction

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (n < budget && (!srcs_empty() || busy !== 1'b0 || rsp_if.m_tvalid !== 1'b0));
      check("wait_idle_in_budget", 128'(n < budget), 128'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < NS; i++) src_q[i].delete();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   int base;
   int ibase;
   int n;
   int exp_tids[6];
   logic [DW-1:0] snap;

   initial begin
      rsp_if.s_tvalid = '0;
      rsp_if.s_tdata  = '0;
      rsp_if.s_tkeep  = '0;
      rsp_if.s_tlast  = '0;
      rsp_if.m_tready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_m_tvalid", 128'(rsp_if.m_tvalid), 128'(0));
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_err", 128'(err_overlen), 128'(0));
      check("reset_s_tready", 128'(rsp_if.s_tready), 128'(0));

      // Single source: three beats from src2, one cycle latency, no gaps.
      base  = out_tid.size();
      ibase = in_cyc.size();
      send_pkt(2, 3, -1);
      wait_idle(100);
      check("single_count", 128'(out_tid.size() - base), 128'(3));
      if (out_tid.size() - base >= 3 && in_cyc.size() > ibase) begin
         for (int j = 0; j < 3; j++) begin
            check("single_tid", 128'(out_tid[base+j]), 128'(2));
            check("single_last", 128'(out_last[base+j]), 128'(j == 2));
            check("single_cycle", 128'(out_cyc[base+j]), 128'(in_cyc[ibase] + 1 + j));
         end
      end

      // Round robin from rr_ptr=0 with every source holding a 1-beat packet.
      do_reset();
      base = out_tid.size();
      send_pkt(0, 1, -1);
      send_pkt(1, 1, -1);
      send_pkt(2, 1, -1);
      send_pkt(3, 1, -1);
      send_pkt(0, 1, -1);
      wait_idle(100);
      check("rr_count", 128'(out_tid.size() - base), 128'(5));
      if (out_tid.size() - base >= 5) begin
         exp_tids = '{0, 1, 2, 3, 0, 0};
         for (int j = 0; j < 5; j++) begin
            check("rr_tid", 128'(out_tid[base+j]), 128'(exp_tids[j]));
            if (j > 0) check("rr_no_gap", 128'(out_cyc[base+j] - out_cyc[base+j-1]), 128'(1));
         end
      end

      // Lock: src0 holds the grant across its own valid gap while src1 waits.
      base = out_tid.size();
      send_pkt(0, 4, 2);
      tick();
      send_pkt(1, 2, -1);
      check("lock_ready_src0", 128'(rsp_if.s_tready), 128'(4'b0001));
      tick();
      check("lock_src1_blocked", 128'(rsp_if.s_tready[1]), 128'(0));
      wait_idle(100);
      check("lock_count", 128'(out_tid.size() - base), 128'(6));
      if (out_tid.size() - base >= 6) begin
         exp_tids = '{0, 0, 0, 0, 1, 1};
         for (int j = 0; j < 6; j++) check("lock_tid", 128'(out_tid[base+j]), 128'(exp_tids[j]));
      end

      // Backpressure: five stalled cycles mid-packet.
      base  = out_tid.size();
      ibase = in_cyc.size();
      send_pkt(1, 6, -1);
      tick();
      tick();
      rsp_if.m_tready = 1'b0;
      snap = rsp_if.m_tdata;
      check("bp_valid", 128'(rsp_if.m_tvalid), 128'(1));
      repeat (5) begin
         tick();
         check("bp_stable", 128'(rsp_if.m_tdata), 128'(snap));
      end
      check("bp_ready_low", 128'(rsp_if.s_tready), 128'(0));
      check("bp_buffered", 128'((in_cyc.size() - ibase) - (out_tid.size() - base)), 128'(2));
      rsp_if.m_tready = 1'b1;
      wait_idle(100);
      check("bp_count", 128'(out_tid.size() - base), 128'(6));
      if (out_tid.size() - base >= 6) begin
         for (int j = 0; j < 6; j++) begin
            check("bp_tid", 128'(out_tid[base+j]), 128'(1));
            check("bp_seq", 128'(out_data[base+j][15:0]), 128'(j));
         end
      end

      // Over-length: 17 beats against MAX_BEATS=16.
      check("ovl_err_before", 128'(err_overlen), 128'(0));
      base = out_tid.size();
      send_pkt(2, 17, -1);
      wait_idle(200);
      check("ovl_err_after", 128'(err_overlen), 128'(1));
      check("ovl_count", 128'(out_tid.size() - base), 128'(17));
      if (out_tid.size() - base >= 17) begin
         n = 0;
         for (int j = 0; j < 17; j++) n += int'(out_last[base+j]);
         check("ovl_one_last", 128'(n), 128'(1));
         check("ovl_last_pos", 128'(out_last[base+16]), 128'(1));
      end

      // Reset during beat 2 of a 4-beat packet, then src3 must win from rr_ptr=0.
      ibase = in_cyc.size();
      send_pkt(1, 4, -1);
      n = 0;
      do begin
         tick();
         n++;
      end while (n < 50 && in_cyc.size() - ibase < 1);
      check("mid_first_beat", 128'(in_cyc.size() - ibase), 128'(1));
      rst = 1'b1;
      for (int i = 0; i < NS; i++) src_q[i].delete();
      tick();
      rst = 1'b0;
      check("mid_m_tvalid", 128'(rsp_if.m_tvalid), 128'(0));
      check("mid_busy", 128'(busy), 128'(0));
      check("mid_err", 128'(err_overlen), 128'(0));
      base = out_tid.size();
      send_pkt(3, 1, -1);
      tick();
      check("mid_grant_src3", 128'(rsp_if.s_tready), 128'(4'b1000));
      wait_idle(100);
      check("mid_count", 128'(out_tid.size() - base), 128'(1));
      if (out_tid.size() - base >= 1) check("mid_tid", 128'(out_tid[base]), 128'(3));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
